cp0_exc_ctrl: RTL and testbench

Parametrised coprocessor-0 exception controller. It generalises the 3-source CP0 to N_SRC sources with per-source edge-detected pending latches, a fixed-priority arbiter and an explicit take/handler/return state machine. It sits beside the PC/ID stage and serves mfc0/mtc0/eret. It supplies the EPC, the handler entry address and the exception cause to the datapath.

---
 rtl/cp0_pkg.sv | 22 ++
 rtl/cp0_prio_arb.sv | 24 ++
 rtl/cp0_exc_ctrl.sv | 162 ++++++++++++++++
 tb/tb_cp0_exc_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// cp0_pkg: shared types and constants for the CP0 exception controller.
// Rev 1.0
`default_nettype none

package cp0_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_TAKE    = 2'd1,
    ST_HANDLER = 2'd2
  } cp0_state_t;

  localparam logic [1:0] SEL_EPC    = 2'b00;
  localparam logic [1:0] SEL_STATUS = 2'b01;
  localparam logic [1:0] SEL_MASK   = 2'b10;
  localparam logic [1:0] SEL_CAUSE  = 2'b11;

  localparam logic [5:0] ERET_FUNCT = 6'b011000;

endpackage

`default_nettype wire

// File: rtl/cp0_prio_arb.sv
// cp0_prio_arb: N_SRC-wide priority encoder, highest set index wins.
// Rev 1.0
`default_nettype none

module cp0_prio_arb #(
  parameter int N_SRC = 3
) (
  input  logic [N_SRC-1:0] req,
  output logic             valid,
  output logic [4:0]       id
);

  always_comb begin
    valid = |req;
    id    = 5'd0;
    // Ascending scan so the last (highest) set bit overrides lower ones.
    for (int i = 0; i < N_SRC; i++) begin
      if (req[i]) id = 5'(i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/cp0_exc_ctrl.sv
// cp0_exc_ctrl: N_SRC-source CP0 exception controller (EPC/Status/Mask/Cause,
// take/handler/return FSM). Optional macro VECTORED_EN: per-source handler vectors. Rev 1.0
`default_nettype none

module cp0_exc_ctrl
  import cp0_pkg::*;
#(
  parameter int          N_SRC        = 3,
  parameter logic [31:0] HANDLER_BASE = 32'h0000_3000,
  parameter logic [31:0] VEC_STRIDE   = 32'h0000_0010
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] exp_src,
  input  logic             enable,
  input  logic [31:0]      instr,
  input  logic [31:0]      pc_in,
  input  logic [31:0]      din,
  output logic [31:0]      pc_out,
  output logic [31:0]      handler_pc,
  output logic [31:0]      dout,
  output logic             ex_reg_write,
  output logic             is_eret,
  output logic             has_exp,
  output logic             exp_block,
  output logic [4:0]       exc_code
);

  cp0_state_t       state;
  logic [31:0]      epc;
  logic             status;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] src_q;
  logic [4:0]       take_id;

  logic [1:0]       sel;
  logic             wr;
  logic             eret_go;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] pend_set;
  logic [N_SRC-1:0] pend_clr;
  logic [N_SRC-1:0] arb_req;
  logic             arb_valid;
  logic [4:0]       arb_id;
  logic             go_take;
  logic             unused_instr;

  assign ex_reg_write = ~instr[23];
  assign is_eret      = (instr[5:0] == ERET_FUNCT);
  assign sel          = instr[12:11];
  assign wr           = enable & ~ex_reg_write;
  assign eret_go      = enable & is_eret;

  assign rise     = exp_src & ~src_q;
  assign pend_set = rise & ~mask;
  assign arb_req  = pending & ~mask;
  assign go_take  = arb_valid & ~status;

  assign pc_out    = epc;
  assign exp_block = status;

  assign unused_instr = ^{instr[31:24], instr[22:13], instr[10:6]};

  cp0_prio_arb #(
    .N_SRC (N_SRC)
  ) u_arb (
    .req   (arb_req),
    .valid (arb_valid),
    .id    (arb_id)
  );

  always_comb begin
    pend_clr = '0;
    for (int i = 0; i < N_SRC; i++) begin
      pend_clr[i] = (state == ST_TAKE) && (take_id == 5'(i));
    end
  end

  always_comb begin
    dout = '0;
    case (sel)
      SEL_EPC:    dout = epc;
      SEL_STATUS: dout[0] = status;
      SEL_MASK:   dout[N_SRC-1:0] = mask;
      SEL_CAUSE: begin
        dout[4:0]            = exc_code;
        dout[16+N_SRC-1:16]  = pending;
      end
      default:    dout = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      epc      <= '0;
      status   <= 1'b0;
      mask     <= '0;
      pending  <= '0;
      src_q    <= '0;
      take_id  <= '0;
      has_exp  <= 1'b0;
      exc_code <= '0;
`ifdef VECTORED_EN
      handler_pc <= HANDLER_BASE;
`endif
    end else begin
      src_q   <= exp_src;
      // A new rise on the source being taken re-arms it: set beats clear.
      pending <= (pending & ~pend_clr) | pend_set;
      has_exp <= 1'b0;

      if (wr && sel == SEL_MASK) mask <= din[N_SRC-1:0];

      // EPC/Status software writes are dropped while the take owns them.
      if (state != ST_TAKE) begin
        if (wr && sel == SEL_EPC)    epc    <= din;
        if (wr && sel == SEL_STATUS) status <= din[0];
        if (eret_go)                 status <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (go_take) begin
            state   <= ST_TAKE;
            has_exp <= 1'b1;
            take_id <= arb_id;
          end
        end
        ST_TAKE: begin
          epc      <= pc_in;
          exc_code <= take_id;
          status   <= 1'b1;
          state    <= ST_HANDLER;
`ifdef VECTORED_EN
          handler_pc <= HANDLER_BASE + 32'(take_id) * VEC_STRIDE;
`endif
        end
        ST_HANDLER: begin
          if (eret_go) begin
            state <= ST_IDLE;
          end else if (go_take) begin
            state   <= ST_TAKE;
            has_exp <= 1'b1;
            take_id <= arb_id;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifndef VECTORED_EN
  logic unused_stride;
  assign unused_stride = ^VEC_STRIDE;
  assign handler_pc    = HANDLER_BASE;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cp0_exc_ctrl.sv
// tb_cp0_exc_ctrl: scoreboard-driven self-checking bench for cp0_exc_ctrl.
`default_nettype none

module tb_cp0_exc_ctrl;

  localparam int          N    = 3;
  localparam logic [31:0] BASE = 32'h0000_3000;
  localparam logic [31:0] MTC0 = 32'h4080_0000;
  localparam logic [31:0] MFC0 = 32'h4000_0000;
  localparam logic [31:0] ERET = 32'h4200_0018;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  exp_src;
  logic          enable;
  logic [31:0]   instr, pc_in, din;
  logic [31:0]   pc_out, handler_pc, dout;
  logic          ex_reg_write, is_eret, has_exp, exp_block;
  logic [4:0]    exc_code;

  typedef struct {
    logic [4:0]  code;
    logic [31:0] epc;
  } take_t;

  take_t exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  always #5 clk = ~clk;

  cp0_exc_ctrl #(.N_SRC(N)) dut (
    .clk          (clk),
    .reset        (reset),
    .exp_src      (exp_src),
    .enable       (enable),
    .instr        (instr),
    .pc_in        (pc_in),
    .din          (din),
    .pc_out       (pc_out),
    .handler_pc   (handler_pc),
    .dout         (dout),
    .ex_reg_write (ex_reg_write),
    .is_eret      (is_eret),
    .has_exp      (has_exp),
    .exp_block    (exp_block),
    .exc_code     (exc_code)
  );

  function automatic logic [31:0] cp0_op(input logic [31:0] base, input logic [1:0] sel);
    return base | ({30'b0, sel} << 11);
  endfunction

  function automatic logic [31:0] exp_handler(input logic [4:0] code);
`ifdef VECTORED_EN
    return BASE + 32'(code) * 32'h10;
`else
    return BASE + 32'(code) * 32'h0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input logic [1:0] sel, input logic [31:0] data);
    instr  = cp0_op(MTC0, sel);
    din    = data;
    enable = 1'b1;
    tick();
    enable = 1'b0;
    instr  = 32'h0;
  endtask

  task automatic do_eret();
    instr  = ERET;
    enable = 1'b1;
    tick();
    enable = 1'b0;
    instr  = 32'h0;
  endtask

  task automatic wait_take(input int max, output int lat);
    lat = -1;
    for (int c = 1; c <= max; c++) begin
      tick();
      if (has_exp === 1'b1) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; exp_src = '0; enable = 1'b0; instr = 32'h0; pc_in = 32'h0; din = 32'h0;
    tick(); tick();
    reset = 1'b0;
    n_tests++; if (pc_out !== 32'h0) begin n_fail++; $display("FAIL reset_pc_out: got %h want %h", pc_out, 32'h0); end
    n_tests++; if (exp_block !== 1'b0) begin n_fail++; $display("FAIL reset_exp_block: got %b want 0", exp_block); end
    n_tests++; if (has_exp !== 1'b0) begin n_fail++; $display("FAIL reset_has_exp: got %b want 0", has_exp); end
    n_tests++; if (exc_code !== 5'd0) begin n_fail++; $display("FAIL reset_exc_code: got %0d want 0", exc_code); end
    n_tests++; if (handler_pc !== BASE) begin n_fail++; $display("FAIL reset_handler_pc: got %h want %h", handler_pc, BASE); end
    instr = cp0_op(MFC0, 2'b11); #1;
    n_tests++; if (dout !== 32'h0) begin n_fail++; $display("FAIL reset_cause: got %h want 0", dout); end
    n_tests++; if (ex_reg_write !== 1'b1) begin n_fail++; $display("FAIL mfc0_reg_write: got %b want 1", ex_reg_write); end
    instr = 32'h0;
  endtask

  task automatic test_single_take();
    int    lat;
    take_t e;
    pc_in = 32'h1234_5678;
    exp_q.push_back('{code: 5'd2, epc: 32'h1234_5678});
    exp_src = 3'b100;
    wait_take(6, lat);
    n_tests++; if (lat != 2) begin n_fail++; $display("FAIL single_latency: got %0d want 2", lat); end
    tick();
    e = exp_q.pop_front();
    n_tests++; if (has_exp !== 1'b0) begin n_fail++; $display("FAIL single_pulse_width: has_exp got %b want 0", has_exp); end
    n_tests++; if (exc_code !== e.code) begin n_fail++; $display("FAIL single_exc_code: got %0d want %0d", exc_code, e.code); end
    n_tests++; if (pc_out !== e.epc) begin n_fail++; $display("FAIL single_epc: got %h want %h", pc_out, e.epc); end
    n_tests++; if (exp_block !== 1'b1) begin n_fail++; $display("FAIL single_block: got %b want 1", exp_block); end
    exp_src = '0;
    instr = ERET; #1;
    n_tests++; if (is_eret !== 1'b1) begin n_fail++; $display("FAIL is_eret_decode: got %b want 1", is_eret); end
    do_eret();
    n_tests++; if (exp_block !== 1'b0) begin n_fail++; $display("FAIL eret_unblock: got %b want 0", exp_block); end
  endtask

  task automatic test_priority();
    int    lat;
    take_t e;
    for (int k = 0; k < 3; k++) exp_q.push_back('{code: 5'(2 - k), epc: 32'hA000_0000 + 32'(k)});
    exp_src = 3'b111;
    for (int k = 0; k < 3; k++) begin
      pc_in = 32'hA000_0000 + 32'(k);
      if (k == 0) begin
        wait_take(6, lat);
        n_tests++; if (lat != 2) begin n_fail++; $display("FAIL prio_latency%0d: got %0d want 2", k, lat); end
      end else begin
        do_eret();
        wait_take(6, lat);
        n_tests++; if (lat != 1) begin n_fail++; $display("FAIL prio_latency%0d: got %0d cycles after eret+1 want 1", k, lat); end
      end
      exp_src = '0;
      tick();
      e = exp_q.pop_front();
      n_tests++; if (exc_code !== e.code) begin n_fail++; $display("FAIL prio_code%0d: got %0d want %0d", k, exc_code, e.code); end
      n_tests++; if (pc_out !== e.epc) begin n_fail++; $display("FAIL prio_epc%0d: got %h want %h", k, pc_out, e.epc); end
    end
    do_eret();
    wait_take(5, lat);
    n_tests++; if (lat != -1) begin n_fail++; $display("FAIL prio_no_extra: spurious take after %0d want none", lat); end
  endtask

  task automatic test_mask();
    int    lat;
    take_t e;
    mtc0(2'b10, 32'hFFFF_FFF9);
    instr = cp0_op(MFC0, 2'b10); #1;
    n_tests++; if (dout !== 32'h1) begin n_fail++; $display("FAIL mask_read: got %h want %h", dout, 32'h1); end
    instr = 32'h0;
    exp_src = 3'b001; tick(); exp_src = '0;
    wait_take(5, lat);
    n_tests++; if (lat != -1) begin n_fail++; $display("FAIL masked_no_take: take after %0d want none", lat); end
    instr = cp0_op(MFC0, 2'b11); #1;
    n_tests++; if (dout[16] !== 1'b0) begin n_fail++; $display("FAIL masked_rise_pending: got %b want 0", dout[16]); end
    instr = 32'h0;
    mtc0(2'b10, 32'h0);
    // Latch source 0 while blocked, then mask it: pending must survive the mask.
    pc_in = 32'h0000_B000;
    exp_q.push_back('{code: 5'd1, epc: 32'h0000_B000});
    exp_src = 3'b010;
    wait_take(6, lat);
    exp_src = '0;
    tick();
    e = exp_q.pop_front();
    n_tests++; if (exc_code !== e.code) begin n_fail++; $display("FAIL mask_pre_code: got %0d want %0d", exc_code, e.code); end
    exp_src = 3'b001; tick(); exp_src = '0; tick();
    mtc0(2'b10, 32'h1);
    do_eret();
    wait_take(5, lat);
    n_tests++; if (lat != -1) begin n_fail++; $display("FAIL mask_suppress: take after %0d want none", lat); end
    instr = cp0_op(MFC0, 2'b11); #1;
    n_tests++; if (dout[18:16] !== 3'b001) begin n_fail++; $display("FAIL mask_cause_pending: got %b want 001", dout[18:16]); end
    instr = 32'h0;
    exp_q.push_back('{code: 5'd0, epc: 32'h0000_B000});
    mtc0(2'b10, 32'h0);
    wait_take(5, lat);
    n_tests++; if (lat == -1) begin n_fail++; $display("FAIL unmask_take: got none want take"); end
    tick();
    e = exp_q.pop_front();
    n_tests++; if (exc_code !== e.code) begin n_fail++; $display("FAIL unmask_code: got %0d want %0d", exc_code, e.code); end
    do_eret();
  endtask

  task automatic test_epc_conflict();
    take_t e;
    pc_in = 32'hC0DE_0001;
    exp_q.push_back('{code: 5'd1, epc: 32'hC0DE_0001});
    exp_src = 3'b010;
    tick(); tick();
    n_tests++; if (has_exp !== 1'b1) begin n_fail++; $display("FAIL conflict_take_cycle: has_exp got %b want 1", has_exp); end
    instr = cp0_op(MTC0, 2'b00); din = 32'hFEED_FACE; enable = 1'b1;
    tick();
    enable = 1'b0; instr = 32'h0; exp_src = '0;
    e = exp_q.pop_front();
    n_tests++; if (pc_out !== e.epc) begin n_fail++; $display("FAIL conflict_epc: got %h want %h", pc_out, e.epc); end
    n_tests++; if (exc_code !== e.code) begin n_fail++; $display("FAIL conflict_code: got %0d want %0d", exc_code, e.code); end
    n_tests++; if (handler_pc !== exp_handler(e.code)) begin n_fail++; $display("FAIL handler_pc: got %h want %h", handler_pc, exp_handler(e.code)); end
    mtc0(2'b00, 32'hFEED_FACE);
    instr = cp0_op(MFC0, 2'b00); #1;
    n_tests++; if (dout !== 32'hFEED_FACE) begin n_fail++; $display("FAIL mfc0_epc: got %h want %h", dout, 32'hFEED_FACE); end
    instr = 32'h0;
    do_eret();
  endtask

  task automatic test_reset_in_handler();
    int    lat;
    take_t e;
    pc_in = 32'h0000_D000;
    exp_q.push_back('{code: 5'd2, epc: 32'h0000_D000});
    exp_src = 3'b100;
    wait_take(6, lat);
    exp_src = '0;
    tick();
    e = exp_q.pop_front();
    n_tests++; if (pc_out !== e.epc) begin n_fail++; $display("FAIL rh_epc: got %h want %h", pc_out, e.epc); end
    exp_src = 3'b001; tick(); exp_src = '0; tick();
    reset = 1'b1; tick(); reset = 1'b0;
    n_tests++; if (exp_block !== 1'b0) begin n_fail++; $display("FAIL rh_block: got %b want 0", exp_block); end
    n_tests++; if (pc_out !== 32'h0) begin n_fail++; $display("FAIL rh_pc_out: got %h want 0", pc_out); end
    n_tests++; if (exc_code !== 5'd0) begin n_fail++; $display("FAIL rh_exc_code: got %0d want 0", exc_code); end
    n_tests++; if (handler_pc !== BASE) begin n_fail++; $display("FAIL rh_handler_pc: got %h want %h", handler_pc, BASE); end
    instr = cp0_op(MFC0, 2'b11); #1;
    n_tests++; if (dout !== 32'h0) begin n_fail++; $display("FAIL rh_cause: got %h want 0", dout); end
    instr = 32'h0;
    wait_take(5, lat);
    n_tests++; if (lat != -1) begin n_fail++; $display("FAIL rh_no_take: take after %0d want none", lat); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_take();
    test_priority();
    test_mask();
    test_epc_conflict();
    test_reset_in_handler();
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
